// File: rtl/pwm_audio_capture_pkg.sv
// Shared constants and FSM state encoding for the PWM audio capture block.
// PWM_BITS_DEF must match the sound_effect transmitter.
package pwm_audio_capture_pkg;
   localparam int PWM_BITS_DEF     = 8;
   localparam int LOCK_PERIODS_DEF = 4;

   typedef enum logic [1:0] {
      CAP_OFF,
      CAP_SEEK,
      CAP_MEASURE
   } cap_state_t;
endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer for aud_sd/aud_pwm plus a registered pwm rising-edge pulse.
// pwm_rise is high in the first cycle that pwm_sync is high.
module pwm_edge_sync (
   input  logic clk_in,
   input  logic rst_n_in,
   input  logic sd_in,
   input  logic pwm_in,
   output logic sd_sync,
   output logic pwm_sync,
   output logic pwm_rise
);
   logic sd_meta;
   logic pwm_meta;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         sd_meta  <= 1'b0;
         sd_sync  <= 1'b0;
         pwm_meta <= 1'b0;
         pwm_sync <= 1'b0;
         pwm_rise <= 1'b0;
      end else begin
         sd_meta  <= sd_in;
         sd_sync  <= sd_meta;
         pwm_meta <= pwm_in;
         pwm_sync <= pwm_meta;
         pwm_rise <= pwm_meta & ~pwm_sync;
      end
   end
endmodule

// File: rtl/pwm_audio_capture.sv
// Decodes the aud_sd/aud_pwm pair back into PCM samples (high cycles per PWM period).
// Optional tone-period measurement is built when PWM_FREQ_MEAS_EN is defined.
//
// state       | meaning
// CAP_OFF     | amplifier shut down; everything held cleared
// CAP_SEEK    | waiting for the first pwm rising edge to set period alignment
// CAP_MEASURE | counting period and high cycles; emits samples once locked
module pwm_audio_capture
   import pwm_audio_capture_pkg::*;
#(
   parameter int PWM_BITS     = PWM_BITS_DEF,
   parameter int LOCK_PERIODS = LOCK_PERIODS_DEF
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   input  logic                aud_sd_in,
   input  logic                aud_pwm_in,
   output logic [PWM_BITS-1:0] sample_out,
   output logic                sample_valid_out,
   input  logic                sample_ready_in,
   output logic                locked_out,
   output logic                overrun_out,
   output logic [15:0]         tone_period_out,
   output logic                tone_valid_out
);
   localparam int LW = $clog2(LOCK_PERIODS + 1);
   localparam logic [PWM_BITS-1:0] LAST_CNT = '1;
   localparam logic [LW-1:0]       LOCK_MAX = LW'(LOCK_PERIODS);

   logic sd_sync, pwm_sync, pwm_rise;
   cap_state_t state, state_nxt;
   logic [PWM_BITS-1:0] period_cnt, cand;
   logic [PWM_BITS:0]   high_cnt, high_nxt;
   logic [LW-1:0]       lock_cnt, lock_nxt;
   logic misalign, wrap, emit, take;

   pwm_edge_sync u_sync (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .sd_in    (aud_sd_in),
      .pwm_in   (aud_pwm_in),
      .sd_sync  (sd_sync),
      .pwm_sync (pwm_sync),
      .pwm_rise (pwm_rise)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) state <= CAP_OFF;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         CAP_OFF:     if (sd_sync) state_nxt = CAP_SEEK;
         CAP_SEEK:    if (!sd_sync) state_nxt = CAP_OFF;
                      else if (pwm_rise) state_nxt = CAP_MEASURE;
         CAP_MEASURE: if (!sd_sync) state_nxt = CAP_OFF;
         default:     state_nxt = CAP_OFF;
      endcase
   end

   always_comb begin
      high_nxt = high_cnt + {{PWM_BITS{1'b0}}, pwm_sync};
      misalign = (state == CAP_MEASURE) && sd_sync && pwm_rise && (period_cnt != '0);
      wrap     = (state == CAP_MEASURE) && sd_sync && !misalign && (period_cnt == LAST_CNT);
      lock_nxt = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + LW'(1);
      emit     = wrap && (lock_nxt == LOCK_MAX);
      // a fully-high period counts 2**PWM_BITS, which does not fit the sample width
      cand     = high_nxt[PWM_BITS] ? LAST_CNT : high_nxt[PWM_BITS-1:0];
      take     = sample_valid_out && sample_ready_in;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         period_cnt       <= '0;
         high_cnt         <= '0;
         lock_cnt         <= '0;
         locked_out       <= 1'b0;
         overrun_out      <= 1'b0;
         sample_out       <= '0;
         sample_valid_out <= 1'b0;
      end else if (!sd_sync || state == CAP_OFF) begin
         period_cnt       <= '0;
         high_cnt         <= '0;
         lock_cnt         <= '0;
         locked_out       <= 1'b0;
         overrun_out      <= 1'b0;
         sample_out       <= '0;
         sample_valid_out <= 1'b0;
      end else begin
         if (state == CAP_SEEK && pwm_rise) begin
            period_cnt <= PWM_BITS'(1);
            high_cnt   <= (PWM_BITS+1)'(1);
         end else if (state == CAP_MEASURE) begin
            if (misalign) begin
               // the edge cycle itself becomes count 0 of the new period
               period_cnt <= PWM_BITS'(1);
               high_cnt   <= (PWM_BITS+1)'(1);
               lock_cnt   <= '0;
               locked_out <= 1'b0;
            end else if (wrap) begin
               period_cnt <= '0;
               high_cnt   <= '0;
               lock_cnt   <= lock_nxt;
               locked_out <= (lock_nxt == LOCK_MAX);
            end else begin
               period_cnt <= period_cnt + PWM_BITS'(1);
               high_cnt   <= high_nxt;
            end
         end

         if (emit && (!sample_valid_out || take)) begin
            sample_out       <= cand;
            sample_valid_out <= 1'b1;
         end else begin
            if (take) sample_valid_out <= 1'b0;
            if (emit) overrun_out      <= 1'b1;
         end
      end
   end

`ifdef PWM_FREQ_MEAS_EN
   logic        has_prev, prev_below, armed, cur_above;
   logic [15:0] tone_cnt;

   assign cur_above = cand[PWM_BITS-1];

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         has_prev        <= 1'b0;
         prev_below      <= 1'b0;
         armed           <= 1'b0;
         tone_cnt        <= '0;
         tone_period_out <= '0;
         tone_valid_out  <= 1'b0;
      end else if (!sd_sync || state == CAP_OFF || misalign) begin
         has_prev       <= 1'b0;
         prev_below     <= 1'b0;
         armed          <= 1'b0;
         tone_cnt       <= '0;
         tone_valid_out <= 1'b0;
         if (!sd_sync || state == CAP_OFF) tone_period_out <= '0;
      end else begin
         tone_valid_out <= 1'b0;
         if (emit) begin
            has_prev   <= 1'b1;
            prev_below <= !cur_above;
            if (has_prev && prev_below && cur_above) begin
               if (armed) begin
                  tone_period_out <= tone_cnt;
                  tone_valid_out  <= 1'b1;
               end
               armed    <= 1'b1;
               tone_cnt <= 16'd1;
            end else if (armed && tone_cnt != 16'hFFFF) begin
               tone_cnt <= tone_cnt + 16'd1;
            end
         end
      end
   end
`else
   assign tone_period_out = '0;
   assign tone_valid_out  = 1'b0;
`endif
endmodule

// File: tb/tb_pwm_audio_capture.sv
// Directed bench for pwm_audio_capture: per-period vector table plus sd-drop, reset and tone sequences.
module tb_pwm_audio_capture;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sd = 1'b0;
   logic        pwm = 1'b0;
   logic        ready = 1'b1;
   logic [7:0]  sample;
   logic        valid, locked, overrun;
   logic [15:0] tone_period;
   logic        tone_valid;

   int errors = 0;
   int checks = 0;
   int acc_cnt = 0;
   int last_acc = 0;
   int prev_acc = 0;
   int tone_pulses = 0;
   int last_tone = 0;

   always #5 clk = ~clk;

   pwm_audio_capture dut (
      .clk_in           (clk),
      .rst_n_in         (rst_n),
      .aud_sd_in        (sd),
      .aud_pwm_in       (pwm),
      .sample_out       (sample),
      .sample_valid_out (valid),
      .sample_ready_in  (ready),
      .locked_out       (locked),
      .overrun_out      (overrun),
      .tone_period_out  (tone_period),
      .tone_valid_out   (tone_valid)
   );

   always @(negedge clk) begin
      if (rst_n && valid && ready) begin
         acc_cnt  = acc_cnt + 1;
         last_acc = int'(sample);
      end
      if (tone_valid) begin
         tone_pulses = tone_pulses + 1;
         last_tone   = int'(tone_period);
      end
   end

   typedef struct {
      int high;    // high cycles at the start of the period (256 = constant high)
      int glitch;  // extra high pulse at cycles 100..109
      int rdy;
      int e_lock;
      int e_new;   // samples accepted in this period's window
      int e_last;
      int e_valid;
      int e_sout;
      int e_ovr;
   } vec_t;

   localparam int NV = 22;
   vec_t tbl[NV];

   task automatic check(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive_cycle(input logic p);
      pwm = p;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_period(input int high);
      for (int c = 0; c < 256; c++) drive_cycle(c < high);
   endtask

   function automatic logic pwm_at(input vec_t v, input int c);
      return (c < v.high) || (v.glitch != 0 && c >= 100 && c < 110);
   endfunction

   task automatic check_outputs_zero(input string tag);
      check({tag, "_locked"},  int'(locked), 0);
      check({tag, "_valid"},   int'(valid), 0);
      check({tag, "_sample"},  int'(sample), 0);
      check({tag, "_overrun"}, int'(overrun), 0);
      check({tag, "_tone_p"},  int'(tone_period), 0);
      check({tag, "_tone_v"},  int'(tone_valid), 0);
   endtask

   task automatic check_entry(input int k);
      check($sformatf("v%0d_locked", k), int'(locked), tbl[k].e_lock);
      check($sformatf("v%0d_new_samples", k), acc_cnt - prev_acc, tbl[k].e_new);
      if (tbl[k].e_new > 0) check($sformatf("v%0d_last_sample", k), last_acc, tbl[k].e_last);
      check($sformatf("v%0d_valid", k), int'(valid), tbl[k].e_valid);
      if (tbl[k].e_valid != 0) check($sformatf("v%0d_held_sample", k), int'(sample), tbl[k].e_sout);
      check($sformatf("v%0d_overrun", k), int'(overrun), tbl[k].e_ovr);
`ifndef PWM_FREQ_MEAS_EN
      check($sformatf("v%0d_tone_period", k), int'(tone_period), 0);
      check($sformatf("v%0d_tone_valid", k), int'(tone_valid), 0);
`endif
      prev_acc = acc_cnt;
   endtask

   initial begin
      int base;
      //          high gl rdy lock new last valid sout ovr
      tbl[0]  = '{64,  0, 1,  0,  0,  0,   0,  0,   0};
      tbl[1]  = '{64,  0, 1,  0,  0,  0,   0,  0,   0};
      tbl[2]  = '{64,  0, 1,  0,  0,  0,   0,  0,   0};
      tbl[3]  = '{64,  0, 1,  1,  1,  64,  0,  0,   0};
      tbl[4]  = '{64,  0, 1,  1,  1,  64,  0,  0,   0};
      tbl[5]  = '{64,  0, 1,  1,  1,  64,  0,  0,   0};
      tbl[6]  = '{200, 0, 1,  1,  1,  200, 0,  0,   0};
      tbl[7]  = '{200, 0, 0,  1,  0,  0,   1,  200, 0};
      tbl[8]  = '{150, 0, 0,  1,  0,  0,   1,  200, 1};
      tbl[9]  = '{150, 0, 0,  1,  0,  0,   1,  200, 1};
      tbl[10] = '{128, 0, 1,  1,  2,  128, 0,  0,   1};
      tbl[11] = '{0,   0, 1,  1,  1,  0,   0,  0,   1};
      tbl[12] = '{255, 0, 1,  1,  1,  255, 0,  0,   1};
      tbl[13] = '{256, 0, 1,  1,  1,  255, 0,  0,   1};
      tbl[14] = '{256, 0, 1,  1,  1,  255, 0,  0,   1};
      tbl[15] = '{64,  0, 1,  1,  1,  64,  0,  0,   1};
      tbl[16] = '{64,  0, 1,  1,  1,  64,  0,  0,   1};
      tbl[17] = '{64,  1, 1,  0,  0,  0,   0,  0,   1};
      tbl[18] = '{64,  0, 1,  0,  0,  0,   0,  0,   1};
      tbl[19] = '{64,  0, 1,  0,  0,  0,   0,  0,   1};
      tbl[20] = '{64,  0, 1,  0,  0,  0,   0,  0,   1};
      tbl[21] = '{64,  0, 1,  1,  1,  64,  0,  0,   1};

      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst_n = 1'b1;
      sd    = 1'b1;
      repeat (8) drive_cycle(1'b0);
      prev_acc = acc_cnt;

      for (int i = 0; i < NV; i++) begin
         for (int c = 0; c < 256; c++) begin
            drive_cycle(pwm_at(tbl[i], c));
            if (c == 3) begin
               if (i > 0) check_entry(i - 1);
               ready = (tbl[i].rdy != 0);
            end
         end
      end
      repeat (4) drive_cycle(1'b0);
      check_entry(NV - 1);

      // sd falls mid-period: no partial sample, sticky overrun cleared
      repeat (146) drive_cycle(1'b0);
      sd = 1'b0;
      repeat (5) drive_cycle(1'b0);
      check_outputs_zero("sd_drop");
      base = acc_cnt;
      for (int c = 0; c < 300; c++) drive_cycle((c % 256) < 64);
      check("sd_drop_no_sample", acc_cnt - base, 0);
      check("sd_drop_valid", int'(valid), 0);

      // relock, build up a held sample plus overrun, then reset mid-period
      sd = 1'b1;
      repeat (10) drive_cycle(1'b0);
      repeat (5) drive_period(64);
      check("relock_locked", int'(locked), 1);
      check("relock_overrun", int'(overrun), 0);
      ready = 1'b0;
      repeat (2) drive_period(64);
      for (int c = 0; c <= 100; c++) drive_cycle(c < 64);
      check("pre_rst_valid", int'(valid), 1);
      check("pre_rst_sample", int'(sample), 64);
      check("pre_rst_overrun", int'(overrun), 1);
      check("pre_rst_locked", int'(locked), 1);
      rst_n = 1'b0;
      #1;
      check_outputs_zero("async_rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      ready = 1'b1;
      base  = acc_cnt;
      for (int c = 102; c < 256; c++) drive_cycle(c < 64);
      drive_period(64);
      check("post_rst_no_sample", acc_cnt - base, 0);
      check("post_rst_valid", int'(valid), 0);
      check("post_rst_locked", int'(locked), 0);

`ifdef PWM_FREQ_MEAS_EN
      repeat (6) drive_period(64);
      check("tone_pre_locked", int'(locked), 1);
      base = tone_pulses;
      for (int b = 0; b < 4; b++) begin
         repeat (8) drive_period(0);
         repeat (8) drive_period(255);
      end
      repeat (4) drive_cycle(1'b0);
      check("tone_pulses", tone_pulses - base, 3);
      check("tone_period", last_tone, 16);
      check("tone_period_out", int'(tone_period), 16);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
